fpu: RTL and testbench

- Single-precision IEEE-754 floating-point coprocessor on an 8-bit memory-mapped bus.
- Host writes two 32-bit operands bytewise, writes an opcode, issues start, waits for cmd_end, reads the 32-bit result bytewise, then acknowledges with end_ack.
- Sits as a peripheral beside the CPU; cmd_end may drive an interrupt line.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_core.sv | 164 ++++++++++++++++
 rtl/fpu.sv | 97 +++++++++
 tb/tb_fpu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu coprocessor: opcodes, FSM states,
// register map and IEEE-754 special-value constants.
package pa_fpu;

  typedef enum logic [7:0] {
    op_add  = 8'h00,
    op_sub  = 8'h01,
    op_mul  = 8'h02,
    op_log2 = 8'h03
  } e_fpu_op;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_EXEC,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } e_fpu_state;

  localparam logic [3:0] ADDR_OPCODE = 4'h8;
  localparam logic [3:0] ADDR_START  = 4'h9;
  localparam logic [3:0] ADDR_STATUS = 4'hD;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
  } t_fpu_unpacked;

endpackage

// File: rtl/fpu_core.sv
// Staged single-precision datapath: each FSM state advances one stage
// (unpack, exec, normalise); the rounded result is combinational in ROUND.
module fpu_core
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  e_fpu_state  state,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [7:0]  opcode,
  output logic [31:0] result
);

  t_fpu_unpacked ua_d, ua_q, ub_d, ub_q, big;
  logic        spec_d, spec_q;
  logic [31:0] spec_val_d, spec_val_q;
  logic        za, zb, ia, ib, na, nb;

  logic        a_big;
  logic [7:0]  sml_exp, diff, lg_diff, lg_mag;
  logic [23:0] sml_man;
  logic [4:0]  shamt, lz;
  logic [49:0] wide;
  logic [26:0] aligned;
  logic [47:0] prod;

  logic               x_sign_d, x_sign_q, x_zsign_d, x_zsign_q;
  logic signed [9:0]  x_exp_d, x_exp_q;
  logic [27:0]        x_raw_d, x_raw_q;

  logic               n_sign_d, n_sign_q, n_zero_d, n_zero_q;
  logic signed [9:0]  n_exp_d, n_exp_q;
  logic [26:0]        n_man_d, n_man_q;

  logic               round_up;
  logic [24:0]        r_man;
  logic signed [9:0]  r_exp;

  always_comb begin
    za = (op_a[30:23] == 8'h00);
    zb = (op_b[30:23] == 8'h00);
    ia = (op_a[30:0] == INF[30:0]);
    ib = (op_b[30:0] == INF[30:0]);
    na = (op_a[30:23] == 8'hFF) && (op_a[22:0] != '0);
    nb = (op_b[30:23] == 8'hFF) && (op_b[22:0] != '0);
    // Denormal operands collapse to signed zero; B's sign is pre-flipped for sub.
    ua_d = '{sign: op_a[31], exp: op_a[30:23], man: za ? 24'h0 : {1'b1, op_a[22:0]}};
    ub_d = '{sign: op_b[31] ^ (opcode == op_sub), exp: op_b[30:23],
             man: zb ? 24'h0 : {1'b1, op_b[22:0]}};
    spec_d     = 1'b0;
    spec_val_d = QNAN;
    case (opcode)
      op_add, op_sub: begin
        if (na || nb) begin
          spec_d = 1'b1;
        end else if (ia && ib) begin
          spec_d = 1'b1;
          if (ua_d.sign == ub_d.sign) spec_val_d = {ua_d.sign, INF[30:0]};
        end else if (ia || ib) begin
          spec_d     = 1'b1;
          spec_val_d = {ia ? ua_d.sign : ub_d.sign, INF[30:0]};
        end
      end
      op_mul: begin
        if (na || nb || ((ia || ib) && (za || zb))) begin
          spec_d = 1'b1;
        end else if (ia || ib) begin
          spec_d     = 1'b1;
          spec_val_d = {op_a[31] ^ op_b[31], INF[30:0]};
        end else if (za || zb) begin
          spec_d     = 1'b1;
          spec_val_d = {op_a[31] ^ op_b[31], 31'h0};
        end
      end
      op_log2: begin
        spec_d = (op_a[30:23] == 8'hFF) || za || op_a[31];
        if (za)                  spec_val_d = {1'b1, INF[30:0]};
        else if (ia && !op_a[31]) spec_val_d = INF;
      end
      default: spec_d = 1'b1;
    endcase
  end

  always_comb begin
    a_big   = {ua_q.exp, ua_q.man} >= {ub_q.exp, ub_q.man};
    big     = a_big ? ua_q : ub_q;
    sml_exp = a_big ? ub_q.exp : ua_q.exp;
    sml_man = a_big ? ub_q.man : ua_q.man;
    diff    = big.exp - sml_exp;
    // Beyond 26 places the smaller operand only contributes to sticky.
    shamt   = (diff > 8'd26) ? 5'd26 : diff[4:0];
    wide    = {sml_man, 26'h0} >> shamt;
    aligned = {wide[49:24], |wide[23:0]};
    prod    = ua_q.man * ub_q.man;
    lg_diff = ua_q.exp - 8'd127;
    lg_mag  = lg_diff[7] ? (~lg_diff + 8'd1) : lg_diff;
    x_zsign_d = 1'b0;
    case (opcode)
      op_mul: begin
        x_sign_d = ua_q.sign ^ ub_q.sign;
        x_exp_d  = {2'b0, ua_q.exp} + {2'b0, ub_q.exp} - 10'd127;
        x_raw_d  = {prod[47:21], |prod[20:0]};
      end
      op_log2: begin
        x_sign_d = lg_diff[7];
        x_exp_d  = 10'sd153;
        x_raw_d  = {21'h0, lg_mag[6:0]};
      end
      default: begin
        x_sign_d  = big.sign;
        x_zsign_d = ua_q.sign & ub_q.sign;
        x_exp_d   = {2'b0, big.exp};
        x_raw_d   = (ua_q.sign == ub_q.sign) ? {1'b0, big.man, 3'b000} + {1'b0, aligned}
                                             : {1'b0, big.man, 3'b000} - {1'b0, aligned};
      end
    endcase
  end

  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (x_raw_q[i]) lz = 5'(26 - i);
    end
    n_zero_d = (x_raw_q == '0);
    n_sign_d = n_zero_d ? x_zsign_q : x_sign_q;
    if (x_raw_q[27]) begin
      n_man_d = {x_raw_q[27:2], x_raw_q[1] | x_raw_q[0]};
      n_exp_d = x_exp_q + 10'sd1;
    end else begin
      n_man_d = x_raw_q[26:0] << lz;
      n_exp_d = x_exp_q - {5'b0, lz};
    end
  end

  always_comb begin
    round_up = n_man_q[2] & (n_man_q[1] | n_man_q[0] | n_man_q[3]);
    r_man    = {1'b0, n_man_q[26:3]} + {24'h0, round_up};
    r_exp    = n_exp_q + {9'h0, r_man[24]};
    if (spec_q)                          result = spec_val_q;
    else if (n_zero_q || r_exp <= 10'sd0) result = {n_sign_q, 31'h0};
    else if (r_exp >= 10'sd255)          result = {n_sign_q, INF[30:0]};
    else                                 result = {n_sign_q, r_exp[7:0], r_man[22:0]};
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ua_q <= '0; ub_q <= '0; spec_q <= 1'b0; spec_val_q <= '0;
      x_sign_q <= 1'b0; x_zsign_q <= 1'b0; x_exp_q <= '0; x_raw_q <= '0;
      n_sign_q <= 1'b0; n_zero_q <= 1'b0; n_exp_q <= '0; n_man_q <= '0;
    end else begin
      if (state == ST_UNPACK) begin
        ua_q <= ua_d; ub_q <= ub_d; spec_q <= spec_d; spec_val_q <= spec_val_d;
      end
      if (state == ST_EXEC) begin
        x_sign_q <= x_sign_d; x_zsign_q <= x_zsign_d; x_exp_q <= x_exp_d; x_raw_q <= x_raw_d;
      end
      if (state == ST_NORM) begin
        n_sign_q <= n_sign_d; n_zero_q <= n_zero_d; n_exp_q <= n_exp_d; n_man_q <= n_man_d;
      end
    end
  end

endmodule

// File: rtl/fpu.sv
// Memory-mapped FPU coprocessor: 8-bit bus decode, operand/opcode/result
// registers and the command FSM around fpu_core.
module fpu
  import pa_fpu::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  input  logic [3:0] addr,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic       end_ack,
  output logic       cmd_end,
  output logic       busy
);

  e_fpu_state  state_d, state_q;
  logic [31:0] a_d, a_q, b_d, b_q, result_d, result_q, core_result;
  logic [7:0]  opcode_d, opcode_q;
  logic        wr_d, wr_q, we, idle;
  logic [1:0]  rsel;

  fpu_core u_core (
    .clk    (clk),
    .arst   (arst),
    .state  (state_q),
    .op_a   (a_q),
    .op_b   (b_q),
    .opcode (opcode_q),
    .result (core_result)
  );

  always_comb begin
    wr_d     = wr;
    // One write per strobe: only the first low sample after a high one counts.
    we       = !cs && !wr && wr_q;
    idle     = (state_q == ST_IDLE);
    a_d      = a_q;
    b_d      = b_q;
    opcode_d = opcode_q;
    state_d  = state_q;
    if (we && idle) begin
      if (addr[3:2] == 2'b00) a_d[{addr[1:0], 3'b000} +: 8] = databus_in;
      if (addr[3:2] == 2'b01) b_d[{addr[1:0], 3'b000} +: 8] = databus_in;
      if (addr == ADDR_OPCODE) opcode_d = databus_in;
    end
    case (state_q)
      ST_IDLE:   if (we && addr == ADDR_START) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_NORM;
      ST_NORM:   state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_DONE;
      ST_DONE:   if (end_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    result_d = (state_q == ST_ROUND) ? core_result : result_q;
  end

  always_comb begin
    busy        = (state_q == ST_UNPACK) || (state_q == ST_EXEC) ||
                  (state_q == ST_NORM) || (state_q == ST_ROUND);
    cmd_end     = (state_q == ST_DONE);
    rsel        = addr[1:0] - 2'd1;
    databus_out = '0;
    if (!cs && !rd) begin
      case (addr)
        4'h0, 4'h1, 4'h2, 4'h3: databus_out = a_q[{addr[1:0], 3'b000} +: 8];
        4'h4, 4'h5, 4'h6, 4'h7: databus_out = b_q[{addr[1:0], 3'b000} +: 8];
        ADDR_OPCODE:            databus_out = opcode_q;
        4'h9, 4'hA, 4'hB, 4'hC: databus_out = result_q[{rsel, 3'b000} +: 8];
        ADDR_STATUS:            databus_out = {6'b0, busy, cmd_end};
        default:                databus_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      result_q <= '0;
      wr_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      wr_q     <= wr_d;
    end
  end

endmodule

// File: tb/tb_fpu.sv
// Directed bench for the fpu coprocessor: bus protocol, timing, handshake,
// mid-operation reset and hand-computed IEEE-754 result vectors.
module tb_fpu;
  import pa_fpu::*;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] databus_in, databus_out;
  logic [3:0] addr;
  logic       cs, rd, wr, end_ack, cmd_end, busy;
  int         n_checks = 0;
  int         n_errors = 0;

  fpu dut (
    .clk         (clk),
    .arst        (arst),
    .databus_in  (databus_in),
    .databus_out (databus_out),
    .addr        (addr),
    .cs          (cs),
    .rd          (rd),
    .wr          (wr),
    .end_ack     (end_ack),
    .cmd_end     (cmd_end),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    for (int i = 0; i < 4; i++) bus_wr(4'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_wr(4'(4 + i), b[8*i +: 8]);
    bus_wr(ADDR_OPCODE, op);
  endtask

  task automatic start_wait(output int cyc, output int bcyc);
    @(negedge clk);
    addr = ADDR_START; cs = 1'b0; wr = 1'b0;
    cyc = 0; bcyc = 0;
    do begin
      @(posedge clk); #1;
      cs = 1'b1; wr = 1'b1;
      cyc++;
      if (busy) bcyc++;
    end while (!cmd_end && cyc < 20);
    check("done_timeout", cmd_end, 1'b1);
  endtask

  task automatic read_res(output logic [31:0] r);
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      bus_rd(4'(9 + i), d);
      r[8*i +: 8] = d;
    end
  endtask

  task automatic ack();
    @(negedge clk); end_ack = 1'b1;
    @(posedge clk); #1;
    check("ack_cmd_end_low", cmd_end, 1'b0);
    @(negedge clk); end_ack = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] op, input logic [31:0] exp);
    int cyc, bcyc;
    logic [31:0] r;
    load_ops(a, b, op);
    start_wait(cyc, bcyc);
    read_res(r);
    check(tag, r, exp);
    ack();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcyc;
    logic [31:0] r;
    logic [7:0] d;
    arst = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
    addr = '0; databus_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_end", cmd_end, 1'b0);
    bus_rd(ADDR_STATUS, d); check("rst_status", d, 8'h00);
    bus_rd(4'h9, d);        check("rst_res0", d, 8'h00);
    @(negedge clk); arst = 1'b1;

    load_ops(32'h3F80_0000, 32'h3F8C_CCCD, 8'h00);
    bus_rd(4'h3, d); check("rd_a3", d, 8'h3F);
    bus_rd(4'h4, d); check("rd_b0", d, 8'hCD);
    start_wait(cyc, bcyc);
    check("start_to_cmd_end", cyc, 5);
    check("busy_cycles", bcyc, 4);
    check("busy_low_at_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("hold_no_ack", cmd_end, 1'b1);
    bus_wr(ADDR_START, 8'h00);
    bus_wr(4'h0, 8'hAA);
    #1 check("restart_ignored", cmd_end, 1'b1);
    check("restart_not_busy", busy, 1'b0);
    bus_rd(ADDR_STATUS, d); check("status_done", d, 8'h01);
    bus_rd(4'h0, d); check("a0_locked", d, 8'h00);
    read_res(r); check("add_1_1.1", r, 32'h4006_6666);
    ack();
    read_res(r); check("result_kept_idle", r, 32'h4006_6666);

    load_ops(32'h4120_0000, 32'h4000_0000, 8'h02);
    @(negedge clk); addr = ADDR_START; cs = 1'b0; wr = 1'b0;
    @(posedge clk); #1 cs = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    check("busy_in_exec", busy, 1'b1);
    arst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_end", cmd_end, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus_rd(4'(9 + i), d);
      check("abort_res_byte", d, 8'h00);
    end
    bus_rd(4'h3, d); check("abort_a3", d, 8'h00);
    @(negedge clk); arst = 1'b1;

    do_op("mul_10x2",      32'h4120_0000, 32'h4000_0000, 8'h02, 32'h41A0_0000);
    do_op("sub_10-2",      32'h4120_0000, 32'h4000_0000, 8'h01, 32'h4100_0000);
    do_op("sub_-2-1",      32'hC000_0000, 32'h3F80_0000, 8'h01, 32'hC040_0000);
    do_op("log2_28",       32'h4D96_890D, 32'h0,         8'h03, 32'h41E0_0000);
    do_op("log2_0.45",     32'h3EE8_39F1, 32'h0,         8'h03, 32'hC000_0000);
    do_op("log2_0.5",      32'h3F00_0000, 32'h0,         8'h03, 32'hBF80_0000);
    do_op("log2_zero",     32'h0000_0000, 32'h0,         8'h03, 32'hFF80_0000);
    do_op("log2_neg",      32'hBF80_0000, 32'h0,         8'h03, QNAN);
    do_op("log2_inf",      32'h7F80_0000, 32'h0,         8'h03, 32'h7F80_0000);
    do_op("add_x_0",       32'h4CBE_BC20, 32'h0,         8'h00, 32'h4CBE_BC20);
    do_op("mul_x_0",       32'h4CBE_BC20, 32'h0,         8'h02, 32'h0000_0000);
    do_op("inf_sub_inf",   32'h7F80_0000, 32'h7F80_0000, 8'h01, QNAN);
    do_op("x_plus_negx",   32'h3F80_0000, 32'hBF80_0000, 8'h00, 32'h0000_0000);
    do_op("rne_tie_even",  32'h3F80_0000, 32'h3380_0000, 8'h00, 32'h3F80_0000);
    do_op("rne_tie_odd",   32'h3F80_0001, 32'h3380_0000, 8'h00, 32'h3F80_0002);
    do_op("mul_overflow",  32'h7F00_0000, 32'h4000_0000, 8'h02, 32'h7F80_0000);
    do_op("mul_denorm_in", 32'h0040_0000, 32'h4000_0000, 8'h02, 32'h0000_0000);
    do_op("mul_underflow", 32'h0080_0000, 32'h3F00_0000, 8'h02, 32'h0000_0000);
    do_op("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 8'h00, QNAN);
    do_op("zero_x_inf",    32'h0000_0000, 32'h7F80_0000, 8'h02, QNAN);
    do_op("bad_opcode",    32'h3F80_0000, 32'h3F80_0000, 8'h05, QNAN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
